// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register.
// Captures EX results for the MEM stage, inserts NOP bubbles when EX stalls
// while MEM runs, and loops the multi-cycle accumulate state back to EX.
module ex_mem #(
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic        ex_cp0_we,
  input  logic [4:0]  ex_cp0_waddr,
  input  logic [31:0] ex_cp0_wdata,
  input  logic [31:0] ex_excepttype,
  input  logic [31:0] ex_current_inst_addr,
  input  logic        ex_is_in_delayslot,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [7:0]  mem_aluop,
  output logic [31:0] mem_mem_addr,
  output logic [31:0] mem_reg2,
  output logic        mem_cp0_we,
  output logic [4:0]  mem_cp0_waddr,
  output logic [31:0] mem_cp0_wdata,
  output logic [31:0] mem_excepttype,
  output logic [31:0] mem_current_inst_addr,
  output logic        mem_is_in_delayslot,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  logic ex_stalled;
  logic mem_stalled;

  assign ex_stalled  = stall[EX_IDX];
  assign mem_stalled = stall[MEM_IDX];

  // Pipeline register: reset, flush, bubble, advance or hold, in that priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wd                <= 5'd0;
      mem_wreg              <= 1'b0;
      mem_wdata             <= 32'd0;
      mem_whilo             <= 1'b0;
      mem_hi                <= 32'd0;
      mem_lo                <= 32'd0;
      mem_aluop             <= 8'd0;
      mem_mem_addr          <= 32'd0;
      mem_reg2              <= 32'd0;
      mem_cp0_we            <= 1'b0;
      mem_cp0_waddr         <= 5'd0;
      mem_cp0_wdata         <= 32'd0;
      mem_excepttype        <= 32'd0;
      mem_current_inst_addr <= 32'd0;
      mem_is_in_delayslot   <= 1'b0;
      hilo_o                <= 64'd0;
      cnt_o                 <= 2'd0;
    end else if (flush) begin
      mem_wd                <= 5'd0;
      mem_wreg              <= 1'b0;
      mem_wdata             <= 32'd0;
      mem_whilo             <= 1'b0;
      mem_hi                <= 32'd0;
      mem_lo                <= 32'd0;
      mem_aluop             <= 8'd0;
      mem_mem_addr          <= 32'd0;
      mem_reg2              <= 32'd0;
      mem_cp0_we            <= 1'b0;
      mem_cp0_waddr         <= 5'd0;
      mem_cp0_wdata         <= 32'd0;
      mem_excepttype        <= 32'd0;
      mem_current_inst_addr <= 32'd0;
      mem_is_in_delayslot   <= 1'b0;
      hilo_o                <= 64'd0;
      cnt_o                 <= 2'd0;
    end else if (ex_stalled && !mem_stalled) begin
      // Bubble: a zeroed slot is a NOP with no writes and no exception.
      mem_wd                <= 5'd0;
      mem_wreg              <= 1'b0;
      mem_wdata             <= 32'd0;
      mem_whilo             <= 1'b0;
      mem_hi                <= 32'd0;
      mem_lo                <= 32'd0;
      mem_aluop             <= 8'd0;
      mem_mem_addr          <= 32'd0;
      mem_reg2              <= 32'd0;
      mem_cp0_we            <= 1'b0;
      mem_cp0_waddr         <= 5'd0;
      mem_cp0_wdata         <= 32'd0;
      mem_excepttype        <= 32'd0;
      mem_current_inst_addr <= 32'd0;
      mem_is_in_delayslot   <= 1'b0;
      hilo_o                <= hilo_i;
      cnt_o                 <= cnt_i;
    end else if (!ex_stalled) begin
      // Advance; also taken for the illegal "MEM stalled, EX running" case.
      mem_wd                <= ex_wd;
      mem_wreg              <= ex_wreg;
      mem_wdata             <= ex_wdata;
      mem_whilo             <= ex_whilo;
      mem_hi                <= ex_hi;
      mem_lo                <= ex_lo;
      mem_aluop             <= ex_aluop;
      mem_mem_addr          <= ex_mem_addr;
      mem_reg2              <= ex_reg2;
      mem_cp0_we            <= ex_cp0_we;
      mem_cp0_waddr         <= ex_cp0_waddr;
      mem_cp0_wdata         <= ex_cp0_wdata;
      mem_excepttype        <= ex_excepttype;
      mem_current_inst_addr <= ex_current_inst_addr;
      mem_is_in_delayslot   <= ex_is_in_delayslot;
      hilo_o                <= 64'd0;
      cnt_o                 <= 2'd0;
    end else begin
      // Both stages frozen: MEM slot holds, accumulate state keeps tracking EX.
      hilo_o                <= hilo_i;
      cnt_o                 <= cnt_i;
    end
  end

endmodule
